// File: rtl/mem_pkg.sv
// Shared types and constants for the data-port memory responder.
// Holds the FSM state encoding, wait counter width and alignment mask.
package mem_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam int CNT_W = 4;
    localparam logic [1:0] BYTE_OFF_MASK = 2'b11;

    function automatic logic is_misaligned(input logic [1:0] byte_off);
        return |(byte_off & BYTE_OFF_MASK);
    endfunction

endpackage

// File: rtl/mem_array.sv
// Word storage for the responder: synchronous write, combinational read.
// Not reset, so contents survive a responder reset.
module mem_array #(
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [31:0]       wdata,
    output logic [31:0]       rdata
);

    logic [31:0] mem [2**ADDR_W];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
    end

    assign rdata = mem[addr];

endmodule

// File: rtl/data_mem_responder.sv
// Multi-cycle memory responder for the core data port: one request at a time,
// WAIT_CYCLES wait states, then a held response until the requester takes it.
//
// state | meaning
// IDLE  | ready for a request; accept latches it
// WAIT  | counting down wait states; commit on the edge leaving WAIT
// RESP  | response presented and held until rsp_ready
module data_mem_responder
    import mem_pkg::*;
#(
    parameter int ADDR_W      = 8,
    parameter int WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);

    state_t             state, state_nxt;
    logic [CNT_W-1:0]   cnt;
    logic               lat_we;
    logic [ADDR_W+1:0]  lat_addr;
    logic [31:0]        lat_wdata;

    logic               accept, commit;
    logic               cur_we, cur_mis, mem_we;
    logic [ADDR_W+1:0]  cur_addr;
    logic [31:0]        cur_wdata, mem_rdata;
    logic               unused_addr_hi;

    // Upper address bits alias by design.
    assign unused_addr_hi = ^req_addr[31:ADDR_W+2];

    assign req_ready = (state == IDLE);
    assign rsp_valid = (state == RESP);
    assign accept    = (state == IDLE) && req_valid;

    always_comb begin
        state_nxt = state;
        commit    = 1'b0;
        case (state)
            IDLE: begin
                if (req_valid) begin
                    if (WAIT_CYCLES == 0) begin
                        commit    = 1'b1;
                        state_nxt = RESP;
                    end else begin
                        state_nxt = WAIT;
                    end
                end
            end
            WAIT: begin
                if (cnt <= CNT_W'(1)) begin
                    commit    = 1'b1;
                    state_nxt = RESP;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // A zero-wait commit happens on the accept edge, before the latch is loaded.
    assign cur_we    = (state == IDLE) ? req_we    : lat_we;
    assign cur_addr  = (state == IDLE) ? req_addr[ADDR_W+1:0] : lat_addr;
    assign cur_wdata = (state == IDLE) ? req_wdata : lat_wdata;
    assign cur_mis   = is_misaligned(cur_addr[1:0]);
    assign mem_we    = commit && cur_we && !cur_mis;

    mem_array #(
        .ADDR_W (ADDR_W)
    ) u_mem_array (
        .clk   (clk),
        .we    (mem_we),
        .addr  (cur_addr[ADDR_W+1:2]),
        .wdata (cur_wdata),
        .rdata (mem_rdata)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt       <= '0;
            lat_we    <= 1'b0;
            lat_addr  <= '0;
            lat_wdata <= '0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
        end else begin
            if (accept) begin
                lat_we    <= req_we;
                lat_addr  <= req_addr[ADDR_W+1:0];
                lat_wdata <= req_wdata;
                cnt       <= CNT_W'(WAIT_CYCLES);
            end else if (state == WAIT) begin
                cnt <= cnt - CNT_W'(1);
            end
            if (commit) begin
                rsp_err   <= cur_mis;
                rsp_rdata <= (cur_we || cur_mis) ? 32'd0 : mem_rdata;
            end
        end
    end

endmodule
